// File: rtl/sram_wb_pkg.sv
// Shared types for the two-master SRAM Wishbone arbiter.
// Bus widths here bound the arbiter's DATA_WIDTH / ADDR_WIDTH.
package sram_wb_pkg;

  localparam int WB_SEL_W = 4;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/sram_wb_rr_pick.sv
// Two-request round-robin pick: a lone requester wins,
// a tie goes to the prioritised index.
module sram_wb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = prio_i;
    unique case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = prio_i;
      default: gnt_idx_o = prio_i;
    endcase
  end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter with timeout watchdog
// in front of the SRAM wrapper; data path is combinational.
module sram_wb_arbiter
  import sram_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DAT_W,
  parameter int ADDR_WIDTH     = WB_ADR_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [WB_SEL_W-1:0]   m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [WB_SEL_W-1:0]   m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [WB_SEL_W-1:0]   s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_ack_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  arb_state_t       state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  wb_req_t req0, req1, own;
  logic    gnt_valid, gnt_idx;
  logic    busy, pass, tmo, own_ack, own_err;

  assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                  sel: m0_sel_i,
                  adr: WB_ADR_W'(m0_adr_i),
                  dat: WB_DAT_W'(m0_dat_i)};
  assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                  sel: m1_sel_i,
                  adr: WB_ADR_W'(m1_adr_i),
                  dat: WB_DAT_W'(m1_dat_i)};
  assign own  = owner_q ? req1 : req0;

  sram_wb_rr_pick u_pick (
    .req_i       ({m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i}),
    .prio_i      (prio_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign busy    = (state_q == BUSY);
  assign pass    = busy & own.cyc;
  assign tmo     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign own_ack = pass & s_ack_i;
  // Ack beats a same-cycle timeout.
  assign own_err = pass & ~s_ack_i & tmo;

  assign s_cyc_o = pass;
  assign s_stb_o = pass & own.stb;
  assign s_we_o  = pass & own.we;
  assign s_sel_o = pass ? own.sel : '0;
  assign s_adr_o = pass ? ADDR_WIDTH'(own.adr) : '0;
  assign s_dat_o = pass ? DATA_WIDTH'(own.dat) : '0;

  assign m0_ack_o = own_ack & ~owner_q;
  assign m1_ack_o = own_ack & owner_q;
  assign m0_err_o = own_err & ~owner_q;
  assign m1_err_o = own_err & owner_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (own_ack || !own.cyc || own_err) state_d = DRAIN;
        else cnt_d = cnt_q + 1'b1;
      end
      // Trailing wrapper ack lands here and is dropped.
      DRAIN: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Scoreboard bench for sram_wb_arbiter with a one-cycle-ack
// SRAM slave model; responses are checked by a monitor.
module tb_sram_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cyc_r [2];
  logic        stb_r [2];
  logic        we_r  [2];
  logic [3:0]  sel_r [2];
  logic [31:0] adr_r [2];
  logic [31:0] dat_r [2];

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic        busy, owner;

  logic        ack_q, force_ack, slave_en;
  logic [31:0] s_rdat;
  logic [31:0] mem [64];

  sram_wb_arbiter dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m0_cyc_i  (cyc_r[0]),
    .m0_stb_i  (stb_r[0]),
    .m0_we_i   (we_r[0]),
    .m0_sel_i  (sel_r[0]),
    .m0_adr_i  (adr_r[0]),
    .m0_dat_i  (dat_r[0]),
    .m0_ack_o  (m0_ack),
    .m0_err_o  (m0_err),
    .m0_dat_o  (m0_rd),
    .m1_cyc_i  (cyc_r[1]),
    .m1_stb_i  (stb_r[1]),
    .m1_we_i   (we_r[1]),
    .m1_sel_i  (sel_r[1]),
    .m1_adr_i  (adr_r[1]),
    .m1_dat_i  (dat_r[1]),
    .m1_ack_o  (m1_ack),
    .m1_err_o  (m1_err),
    .m1_dat_o  (m1_rd),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat),
    .s_ack_i   (ack_q | force_ack),
    .s_dat_i   (s_rdat),
    .busy_o    (busy),
    .owner_o   (owner)
  );

  // SRAM wrapper model: registered ack one cycle after stb
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= slave_en & s_stb & ~ack_q;
      if (s_stb && !ack_q) begin
        s_rdat <= mem[s_adr[7:2]];
        if (s_we) mem[s_adr[7:2]] <= s_dat;
      end
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc_n);
  endtask

  typedef struct {
    int          cyc;
    bit          m;
    bit          err;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q [$];

  task automatic push(input int c, input bit m, input bit err,
                      input bit we, input logic [31:0] adr,
                      input logic [31:0] dat);
    exp_q.push_back('{c, m, err, we, adr, dat});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (m0_ack || m0_err || m1_ack || m1_err)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_cycle", cyc_n, e.cyc);
        chk("resp_master", m1_ack | m1_err, e.m);
        chk("resp_err", m0_err | m1_err, e.err);
        chk("resp_both", (m0_ack | m0_err) & (m1_ack | m1_err), 0);
        chk("resp_s_adr", s_adr, e.adr);
        if (!e.err && e.we) begin
          chk("wr_s_we", s_we, 1);
          chk("wr_s_dat", s_dat, e.dat);
          chk("wr_s_sel", s_sel, 4'hF);
        end else if (!e.err) begin
          chk("rd_data", e.m ? m1_rd : m0_rd, e.dat);
        end
      end
    end
  end

  task automatic sync(output int k);
    @(posedge clk);
    #1;
    k = cyc_n;
  endtask

  task automatic at_cycle(input int c);
    while (cyc_n < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit m, input bit we,
                       input logic [31:0] adr,
                       input logic [31:0] dat, input int hold);
    bit done;
    int n;
    cyc_r[m] = 1'b1;
    stb_r[m] = 1'b1;
    we_r[m]  = we;
    sel_r[m] = 4'hF;
    adr_r[m] = adr;
    dat_r[m] = dat;
    done = 1'b0;
    n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      done = m ? (m1_ack | m1_err) : (m0_ack | m0_err);
    end
    chk(m ? "m1_resp_seen" : "m0_resp_seen", done, 1);
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    cyc_r[m] = 1'b0;
    stb_r[m] = 1'b0;
    we_r[m]  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      cyc_r[i] = 0; stb_r[i] = 0; we_r[i] = 0;
      sel_r[i] = 0; adr_r[i] = 0; dat_r[i] = 0;
    end
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[12] = 32'h12345678;
    force_ack = 1'b0;
    slave_en  = 1'b1;
    s_rdat    = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tie from reset: strict alternation, m0 first
    sync(k);
    for (int j = 0; j < 4; j++) begin
      push(k + 2 + 8 * j, 0, 0, 0, 32'h10, 32'hDEADBEEF);
      push(k + 6 + 8 * j, 1, 0, 0, 32'h30, 32'h12345678);
    end
    fork
      repeat (4) drive(0, 0, 32'h10, 0, 0);
      repeat (4) drive(1, 0, 32'h30, 0, 0);
    join

    // Lone m0 read
    sync(k);
    push(k + 2, 0, 0, 0, 32'h10, 32'hDEADBEEF);
    fork
      drive(0, 0, 32'h10, 0, 0);
      begin
        at_cycle(k + 1);
        @(negedge clk);
        chk("a_busy", busy, 1);
        chk("a_s_stb", s_stb, 1);
        chk("a_s_adr", s_adr, 32'h10);
        at_cycle(k + 4);
        @(negedge clk);
        chk("a_idle", busy, 0);
        chk("a_owner_kept", owner, 0);
      end
    join

    // m0 just finished, so m1 wins the tie
    sync(k);
    push(k + 2, 1, 0, 0, 32'h30, 32'h12345678);
    push(k + 6, 0, 0, 0, 32'h10, 32'hDEADBEEF);
    fork
      drive(0, 0, 32'h10, 0, 0);
      drive(1, 0, 32'h30, 0, 0);
    join

    // m1 write, holding stb one cycle into DRAIN
    sync(k);
    push(k + 2, 1, 0, 1, 32'h20, 32'hCAFEF00D);
    fork
      drive(1, 1, 32'h20, 32'hCAFEF00D, 1);
      begin
        at_cycle(k + 1);
        @(negedge clk);
        chk("b_s_we", s_we, 1);
        chk("b_s_dat", s_dat, 32'hCAFEF00D);
        chk("b_s_sel", s_sel, 4'hF);
        chk("b_owner", owner, 1);
        at_cycle(k + 3);
        @(negedge clk);
        chk("b_drain_stb", s_stb, 0);
        chk("b_drain_we", s_we, 0);
        chk("b_drain_busy", busy, 1);
      end
    join

    // Timeout on m0, m1 pending then served
    slave_en = 1'b0;
    sync(k);
    push(k + 16, 0, 1, 0, 32'h40, 0);
    push(k + 20, 1, 0, 0, 32'h20, 32'hCAFEF00D);
    fork
      drive(0, 0, 32'h40, 0, 0);
      drive(1, 0, 32'h20, 0, 0);
      begin
        at_cycle(k + 15);
        @(negedge clk);
        chk("t_no_early_err", m0_err, 0);
        chk("t_busy", busy, 1);
        at_cycle(k + 17);
        slave_en = 1'b1;
        @(negedge clk);
        chk("t_drain_cyc", s_cyc, 0);
        chk("t_drain_busy", busy, 1);
      end
    join

    // m0 aborts; late ack lands in DRAIN and is dropped
    slave_en = 1'b0;
    sync(k);
    push(k + 6, 1, 0, 0, 32'h30, 32'h12345678);
    fork
      begin
        cyc_r[0] = 1'b1;
        stb_r[0] = 1'b1;
        we_r[0]  = 1'b0;
        adr_r[0] = 32'h10;
        at_cycle(k + 2);
        cyc_r[0] = 1'b0;
        stb_r[0] = 1'b0;
        @(negedge clk);
        chk("ab_s_cyc", s_cyc, 0);
        chk("ab_s_stb", s_stb, 0);
        chk("ab_owner", owner, 0);
        at_cycle(k + 3);
        force_ack = 1'b1;
        @(negedge clk);
        chk("ab_drain_acks", {m0_ack, m1_ack}, 0);
        chk("ab_drain_busy", busy, 1);
        at_cycle(k + 4);
        force_ack = 1'b0;
        slave_en  = 1'b1;
      end
      drive(1, 0, 32'h30, 0, 0);
    join

    // Reset mid-BUSY while prio favours m1
    sync(k);
    push(k + 2, 0, 0, 0, 32'h10, 32'hDEADBEEF);
    drive(0, 0, 32'h10, 0, 0);
    sync(k);
    cyc_r[1] = 1'b1;
    stb_r[1] = 1'b1;
    adr_r[1] = 32'h30;
    at_cycle(k + 1);
    @(negedge clk);
    chk("r_pre_owner", owner, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_s_cyc", s_cyc, 0);
    chk("r_s_stb", s_stb, 0);
    chk("r_busy", busy, 0);
    chk("r_owner", owner, 0);
    chk("r_m1_ack", m1_ack, 0);
    cyc_r[1] = 1'b0;
    stb_r[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync(k);
    push(k + 2, 0, 0, 0, 32'h10, 32'hDEADBEEF);
    push(k + 6, 1, 0, 0, 32'h30, 32'h12345678);
    fork
      drive(0, 0, 32'h10, 0, 0);
      drive(1, 0, 32'h30, 0, 0);
    join

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
